// File: rtl/usb_fs_tx_arbiter.sv
// usb_fs_tx_arbiter
//
// Shares one USB full-speed transmitter between NUM_REQ packet sources.
// Each requester posts a one-cycle request with its PID. The request is
// latched in a per-requester pending bit and PID register. The arbiter
// grants the transmitter round-robin, one packet at a time. It steers the
// pull-style data interface to the grantee while the packet is in flight,
// and it holds an idle gap of IPG_CYCLES clocks after every packet.
//
// Ports
//   clk                in  block clock, rising edge
//   reset              in  asynchronous reset, active low
//   req_pkt_start      in  [NUM_REQ]    per-requester request pulse
//   req_pid            in  [4*NUM_REQ]  requester PIDs, sampled with the request
//   req_tx_data_avail  in  [NUM_REQ]    requester has a payload byte ready
//   req_tx_data        in  [8*NUM_REQ]  requester payload bytes
//   req_tx_data_get    out [NUM_REQ]    byte-consumed pulse to the grantee
//   req_pkt_end        out [NUM_REQ]    packet-complete pulse to the grantee
//   req_busy           out [NUM_REQ]    requester has a pending/in-flight packet
//   tx_pkt_start       out              start pulse to the transmitter
//   tx_pid             out [4]          PID to the transmitter
//   tx_data_avail      out              data-available to the transmitter
//   tx_data            out [8]          payload byte to the transmitter
//   tx_data_get        in               transmitter consumed a byte
//   tx_pkt_end         in               transmitter finished the packet
//   grant              out [NUM_REQ]    one-hot grantee (START and BUSY only)
module usb_fs_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IPG_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_pkt_start,
  input  logic [4*NUM_REQ-1:0]   req_pid,
  input  logic [NUM_REQ-1:0]     req_tx_data_avail,
  input  logic [8*NUM_REQ-1:0]   req_tx_data,
  output logic [NUM_REQ-1:0]     req_tx_data_get,
  output logic [NUM_REQ-1:0]     req_pkt_end,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic                   tx_pkt_start,
  output logic [3:0]             tx_pid,
  output logic                   tx_data_avail,
  output logic [7:0]             tx_data,
  input  logic                   tx_data_get,
  input  logic                   tx_pkt_end,
  output logic [NUM_REQ-1:0]     grant
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_REQ-1:0]        r_pending;
  logic [NUM_REQ-1:0][3:0]   r_pid;
  logic [IW-1:0]             r_last;
  logic [CW-1:0]             r_cnt;
  logic [NUM_REQ-1:0]        r_grant;
  logic                      r_tx_pkt_start;
  logic [3:0]                r_tx_pid;
  logic [NUM_REQ-1:0]        r_req_pkt_end;

  logic                      w_found;
  logic [IW-1:0]             w_sel;
  logic [IW-1:0]             w_idx;
  logic [NUM_REQ-1:0]        w_clr;
  logic [NUM_REQ-1:0]        w_cap;

  // Round-robin search: first pending requester after the last grantee,
  // wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Completion clears the grantee's pending bit. A new request in the same
  // cycle re-arms it and recaptures its PID, so set takes priority.
  always_comb begin
    w_clr = (r_state == S_BUSY && tx_pkt_end) ? r_grant : '0;
    w_cap = req_pkt_start & (~r_pending | w_clr);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_START;
      S_START: w_state_nxt = S_BUSY;
      S_BUSY:  if (tx_pkt_end) w_state_nxt = S_GAP;
      S_GAP:   if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending      <= '0;
      r_pid          <= '0;
      r_last         <= IW'(NUM_REQ - 1);
      r_cnt          <= '0;
      r_grant        <= '0;
      r_tx_pkt_start <= 1'b0;
      r_tx_pid       <= 4'd0;
      r_req_pkt_end  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_cap;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_cap[i]) r_pid[i] <= req_pid[4*i +: 4];
      end

      // Start and completion pulses last one cycle.
      r_tx_pkt_start <= 1'b0;
      r_tx_pid       <= 4'd0;
      r_req_pkt_end  <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant        <= NUM_REQ'(1) << w_sel;
            r_last         <= w_sel;
            r_tx_pkt_start <= 1'b1;
            r_tx_pid       <= r_pid[w_sel];
          end
        end
        S_BUSY: begin
          if (tx_pkt_end) begin
            r_grant       <= '0;
            r_req_pkt_end <= r_grant;
            r_cnt         <= CW'(IPG_CYCLES - 1);
          end
        end
        S_GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data path is a pure mux onto the grantee, active only in BUSY.
  always_comb begin
    tx_data_avail   = 1'b0;
    tx_data         = 8'd0;
    req_tx_data_get = '0;
    if (r_state == S_BUSY) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_grant[i]) begin
          tx_data_avail      = req_tx_data_avail[i];
          tx_data            = req_tx_data[8*i +: 8];
          req_tx_data_get[i] = tx_data_get;
        end
      end
    end
  end

  assign req_busy     = r_pending;
  assign grant        = r_grant;
  assign tx_pkt_start = r_tx_pkt_start;
  assign tx_pid       = r_tx_pid;
  assign req_pkt_end  = r_req_pkt_end;

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Testbench for usb_fs_tx_arbiter: directed scenarios plus a randomized run.
// A transaction-level model predicts the pending set, grant order and the
// packet start/end cycles. A negedge monitor compares the DUT against those
// predictions and against explicit spot expectations queued by the stimulus.
module tb_usb_fs_tx_arbiter;

  localparam int NR  = 4;
  localparam int IPG = 16;

  localparam int K_BUSY    = 0;
  localparam int K_GRANT   = 1;
  localparam int K_TXSTART = 2;
  localparam int K_TXPID   = 3;
  localparam int K_PKTEND  = 4;
  localparam int K_GET     = 5;
  localparam int K_TXDATA  = 6;
  localparam int K_TIMEOUT = 7;

  logic        clk;
  logic        reset;
  logic [3:0]  req_pkt_start;
  logic [15:0] req_pid;
  logic [3:0]  req_tx_data_avail;
  logic [31:0] req_tx_data;
  logic [3:0]  req_tx_data_get;
  logic [3:0]  req_pkt_end;
  logic [3:0]  req_busy;
  logic        tx_pkt_start;
  logic [3:0]  tx_pid;
  logic        tx_data_avail;
  logic [7:0]  tx_data;
  logic        tx_data_get;
  logic        tx_pkt_end;
  logic [3:0]  grant;

  usb_fs_tx_arbiter #(.NUM_REQ(NR), .IPG_CYCLES(IPG)) dut (
    .clk(clk), .reset(reset),
    .req_pkt_start(req_pkt_start), .req_pid(req_pid),
    .req_tx_data_avail(req_tx_data_avail), .req_tx_data(req_tx_data),
    .req_tx_data_get(req_tx_data_get), .req_pkt_end(req_pkt_end),
    .req_busy(req_busy), .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
    .tx_data_avail(tx_data_avail), .tx_data(tx_data),
    .tx_data_get(tx_data_get), .tx_pkt_end(tx_pkt_end), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         cyc;
    int         g;
    logic [3:0] pid;
  } ev_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } spot_t;

  ev_t   sq[$];         // predicted packet starts
  ev_t   eq[$];         // predicted completion pulses
  spot_t spq[$];        // explicit spot expectations from the stimulus
  int    order_exp[$];  // expected grantee sequence

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  bit         m_pend [NR];
  logic [3:0] m_pid  [NR];
  int         m_last;
  int         m_g;
  int         m_busy_begin;
  int         m_idle_from;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_pend[i] = 1'b0;
      m_pid[i]  = 4'd0;
    end
    m_last       = NR - 1;
    m_g          = -1;
    m_busy_begin = 0;
    m_idle_from  = 0;
    sq.delete();
    eq.delete();
  endtask

  // Apply the inputs seen during cycle c; the result is the state of c+1.
  task automatic model_step(input int c);
    int  clr;
    int  w;
    int  idx;
    bit  found;
    ev_t e;
    clr   = -1;
    found = 1'b0;
    w     = 0;
    if (m_g < 0) begin
      if (c >= m_idle_from) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (!found && m_pend[idx]) begin
            found = 1'b1;
            w     = idx;
          end
        end
        if (found) begin
          m_g          = w;
          m_last       = w;
          m_busy_begin = c + 2;
          e.cyc = c + 1; e.g = w; e.pid = m_pid[w];
          sq.push_back(e);
        end
      end
    end else if (c >= m_busy_begin && tx_pkt_end) begin
      clr = m_g;
      e.cyc = c + 1; e.g = m_g; e.pid = 4'd0;
      eq.push_back(e);
      m_idle_from = c + 1 + IPG;
      m_g         = -1;
    end
    for (int i = 0; i < NR; i++) begin
      if (req_pkt_start[i] && (!m_pend[i] || clr == i)) begin
        m_pend[i] = 1'b1;
        m_pid[i]  = req_pid[4*i +: 4];
      end else if (clr == i) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step(cyc);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [3:0] ev;
    logic [3:0] eg;
    logic [3:0] eend;
    logic       est;
    logic       eavail;
    logic [7:0] edata;
    logic [3:0] eget;
    spot_t      sp;
    int         oi;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_outputs",
            32'({req_tx_data_get, req_pkt_end, req_busy, tx_pkt_start, tx_pid,
                 tx_data_avail, tx_data, grant}), 32'd0);
      end else begin
        for (int i = 0; i < NR; i++) ev[i] = m_pend[i];
        chk("req_busy", 32'(req_busy), 32'(ev));
        eg = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
        chk("grant", 32'(grant), 32'(eg));
        est = (sq.size() > 0) && (sq[0].cyc == cyc);
        chk("tx_pkt_start", 32'(tx_pkt_start), 32'(est));
        if (est) begin
          chk("tx_pid", 32'(tx_pid), 32'(sq[0].pid));
          if (order_exp.size() > 0) begin
            oi = order_exp.pop_front();
            chk("grant_order", 32'(grant), 32'(4'b0001 << oi));
          end
          void'(sq.pop_front());
        end
        eend = 4'b0000;
        if (eq.size() > 0 && eq[0].cyc == cyc) begin
          eend = 4'b0001 << eq[0].g;
          void'(eq.pop_front());
        end
        chk("req_pkt_end", 32'(req_pkt_end), 32'(eend));
        eavail = 1'b0; edata = 8'd0; eget = 4'b0000;
        if (m_g >= 0 && cyc >= m_busy_begin) begin
          eavail = req_tx_data_avail[m_g];
          edata  = req_tx_data[8*m_g +: 8];
          eget   = tx_data_get ? (4'b0001 << m_g) : 4'b0000;
        end
        chk("tx_data_avail", 32'(tx_data_avail), 32'(eavail));
        chk("tx_data", 32'(tx_data), 32'(edata));
        chk("req_tx_data_get", 32'(req_tx_data_get), 32'(eget));
      end
      while (spq.size() > 0 && spq[0].cyc <= cyc) begin
        sp = spq.pop_front();
        case (sp.kind)
          K_BUSY:    chk("spot_req_busy", 32'(req_busy), sp.val);
          K_GRANT:   chk("spot_grant", 32'(grant), sp.val);
          K_TXSTART: chk("spot_tx_pkt_start", 32'(tx_pkt_start), sp.val);
          K_TXPID:   chk("spot_tx_pid", 32'(tx_pid), sp.val);
          K_PKTEND:  chk("spot_req_pkt_end", 32'(req_pkt_end), sp.val);
          K_GET:     chk("spot_req_tx_data_get", 32'(req_tx_data_get), sp.val);
          K_TXDATA:  chk("spot_tx_data", 32'(tx_data), sp.val);
          default:   chk("timeout_waiting_for_start", 32'd0, 32'd1);
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spot(input int c, input int k, input logic [31:0] v);
    spot_t s;
    s.cyc = c; s.kind = k; s.val = v;
    spq.push_back(s);
  endtask

  task automatic clear_inputs();
    req_pkt_start     = 4'b0;
    req_pid           = 16'h0;
    req_tx_data_avail = 4'b0;
    req_tx_data       = 32'h0;
    tx_data_get       = 1'b0;
    tx_pkt_end        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // Acts as the transmitter for one packet: waits for the start pulse,
  // pulls nget bytes, then ends the packet. inj is a request pulse in the
  // first BUSY cycle; end_req/end_pid is a request in the tx_pkt_end cycle.
  task automatic serve(input int nget, input logic [3:0] inj,
                       input logic [3:0] end_req, input logic [15:0] end_pid,
                       output int m);
    int waited;
    waited = 0;
    m = -1;
    while (tx_pkt_start !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) begin
      spot(cyc, K_TIMEOUT, 32'd0);
      return;
    end
    tick();
    req_pkt_start     = inj;
    req_pid           = 16'($urandom);
    req_tx_data       = $urandom;
    req_tx_data_avail = 4'($urandom);
    tick();
    req_pkt_start = 4'b0;
    for (int n = 0; n < nget; n++) begin
      tx_data_get = 1'b1;
      req_tx_data = $urandom;
      tick();
      tx_data_get = 1'b0;
      tick();
    end
    tx_pkt_end    = 1'b1;
    req_pkt_start = end_req;
    req_pid       = end_pid;
    m = cyc;
    tick();
    tx_pkt_end    = 1'b0;
    req_pkt_start = 4'b0;
  endtask

  initial begin
    int c0;
    int m;
    int waited;
    clear_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();

    // Single requester, data steering, completion and gap timing
    c0 = cyc;
    req_pkt_start = 4'b0010;
    req_pid       = 16'h0030;
    spot(c0 + 1, K_BUSY, 32'h2);
    spot(c0 + 2, K_TXSTART, 32'h1);
    spot(c0 + 2, K_GRANT, 32'h2);
    spot(c0 + 2, K_TXPID, 32'h3);
    spot(c0 + 3, K_TXSTART, 32'h0);
    tick();
    req_pkt_start = 4'b0;
    req_pid       = 16'hFFFF;
    tick();
    tick();
    req_tx_data_avail = 4'b1010;
    req_tx_data       = {8'h11, 8'h22, 8'hA5, 8'h33};
    tx_data_get       = 1'b1;
    spot(cyc, K_GET, 32'h2);
    spot(cyc, K_TXDATA, 32'hA5);
    tick();
    tx_data_get       = 1'b0;
    req_tx_data_avail = 4'b0010;
    req_tx_data[15:8] = 8'h5A;
    tick();
    tx_data_get       = 1'b1;
    req_tx_data_avail = 4'b1010;
    spot(cyc, K_GET, 32'h2);
    spot(cyc, K_TXDATA, 32'h5A);
    tick();
    tx_data_get = 1'b0;
    tx_pkt_end  = 1'b1;
    m = cyc;
    spot(m + 1, K_PKTEND, 32'h2);
    spot(m + 1, K_BUSY, 32'h0);
    spot(m + 1, K_GRANT, 32'h0);
    tick();
    tx_pkt_end    = 1'b0;
    req_pkt_start = 4'b0100;
    req_pid       = 16'h0900;
    tick();
    req_pkt_start = 4'b0;
    repeat (3) tick();
    tx_pkt_end  = 1'b1;
    tx_data_get = 1'b1;
    spot(cyc, K_GET, 32'h0);
    tick();
    tx_pkt_end  = 1'b0;
    tx_data_get = 1'b0;
    spot(m + IPG + 1, K_TXSTART, 32'h0);
    spot(m + IPG + 2, K_TXSTART, 32'h1);
    spot(m + IPG + 2, K_GRANT, 32'h4);
    spot(m + IPG + 2, K_TXPID, 32'h9);
    serve(1, 4'b0, 4'b0, 16'h0, m);

    // Round-robin from reset, with re-requests during other packets
    do_reset();
    order_exp.push_back(0);
    order_exp.push_back(1);
    order_exp.push_back(2);
    order_exp.push_back(3);
    order_exp.push_back(0);
    order_exp.push_back(2);
    req_pkt_start = 4'b1111;
    req_pid       = 16'h7654;
    tick();
    req_pkt_start = 4'b0;
    serve(2, 4'b0, 4'b0, 16'h0, m);
    serve(1, 4'b0, 4'b0, 16'h0, m);
    serve(0, 4'b0, 4'b0, 16'h0, m);
    serve(1, 4'b0001, 4'b0, 16'h0, m);
    serve(1, 4'b0100, 4'b0, 16'h0, m);
    serve(1, 4'b0, 4'b0, 16'h0, m);
    repeat (IPG + 2) tick();

    // Duplicate request keeps the first PID; request on completion re-arms
    c0 = cyc;
    req_pkt_start = 4'b0001;
    req_pid       = 16'h0002;
    spot(c0 + 2, K_TXSTART, 32'h1);
    spot(c0 + 2, K_TXPID, 32'h2);
    tick();
    req_pkt_start = 4'b0001;
    req_pid       = 16'h000A;
    tick();
    req_pkt_start = 4'b0;
    serve(2, 4'b0, 4'b0001, 16'h0005, m);
    spot(m + 1, K_BUSY, 32'h1);
    spot(m + 1, K_PKTEND, 32'h1);
    spot(m + IPG + 2, K_TXSTART, 32'h1);
    spot(m + IPG + 2, K_TXPID, 32'h5);
    serve(1, 4'b0, 4'b0, 16'h0, m);

    // Reset in the middle of a packet
    req_pkt_start = 4'b0010;
    req_pid       = 16'h00C0;
    tick();
    req_pkt_start = 4'b0;
    waited = 0;
    while (tx_pkt_start !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) spot(cyc, K_TIMEOUT, 32'd0);
    tick();
    req_tx_data_avail = 4'hF;
    req_tx_data       = 32'hC3C3C3C3;
    tx_data_get       = 1'b1;
    #3 reset = 1'b0;
    tick();
    tick();
    clear_inputs();
    reset = 1'b1;
    order_exp.push_back(0);
    order_exp.push_back(2);
    req_pkt_start = 4'b0101;
    req_pid       = 16'h0D0E;
    tick();
    req_pkt_start = 4'b0;
    serve(1, 4'b0, 4'b0, 16'h0, m);
    serve(1, 4'b0, 4'b0, 16'h0, m);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_pkt_start     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_pid           = 16'($urandom);
      req_tx_data_avail = 4'($urandom);
      req_tx_data       = $urandom;
      tx_data_get       = 1'($urandom);
      tx_pkt_end        = ($urandom_range(0, 9) == 0);
      tick();
    end
    clear_inputs();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_fs_tx_arbiter.md
# usb_fs_tx_arbiter

Shares one USB full-speed transmitter between several packet sources, such as endpoint handlers and the handshake generator. It latches per-requester packet requests and grants the transmitter round-robin, one packet at a time. While a packet is in flight it steers the pull-style data interface to the grantee, and it enforces a minimum idle gap between packets. It sits in the `clk` domain directly in front of the transmitter's `pkt_start`/`pid`/`tx_data_*`/`pkt_end` interface.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IPG_CYCLES`, default 16: `clk` cycles of idle gap after each `pkt_end`; must be ≥1.
- `clk`  in  1  block clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_pkt_start`  in  NUM_REQ  per-requester one-cycle request pulse.
- `req_pid`  in  4*NUM_REQ  PID of requester i on bits [4i+3:4i]; sampled with that requester's `req_pkt_start`.
- `req_tx_data_avail`  in  NUM_REQ  requester i has a payload byte ready.
- `req_tx_data`  in  8*NUM_REQ  payload byte of requester i on bits [8i+7:8i].
- `req_tx_data_get`  out  NUM_REQ  byte-consumed pulse, delivered to the grantee only.
- `req_pkt_end`  out  NUM_REQ  one-cycle completion pulse to the grantee.
- `req_busy`  out  NUM_REQ  requester i has a pending or in-flight packet.
- `tx_pkt_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_pid`  out  4  PID to the transmitter.
- `tx_data_avail`  out  1  data-available signal to the transmitter.
- `tx_data`  out  8  payload byte to the transmitter.
- `tx_data_get`  in  1  transmitter consumed a byte.
- `tx_pkt_end`  in  1  transmitter finished the packet (one-cycle pulse).
- `grant`  out  NUM_REQ  one-hot grantee; all zero outside START and BUSY.

## Operation
- **Pending and PID registers.**
  - Each requester has a `pending[i]` bit and a 4-bit PID register.
  - `req_pkt_start[i]` with `pending[i]`=0 sets `pending[i]` and captures `req_pid[i]`.
  - `req_pkt_start[i]` with `pending[i]`=1 is ignored; the PID is not overwritten.
  - `req_busy` = `pending`.
- **States:** IDLE, START, BUSY, GAP.
- **IDLE**
  - If any `pending` bit is set, select the first set bit searching from `last+1` upward, wrapping modulo NUM_REQ.
  - Register the selection into `grant` and `last`, then go to START.
  - With no `pending` bit set, stay in IDLE.
- **START**
  - `tx_pkt_start`=1 and `tx_pid`=PID register of the grantee, for exactly one cycle.
  - Then go to BUSY.
- **BUSY**
  - `tx_data_avail` = `req_tx_data_avail[g]`; `tx_data` = `req_tx_data[g]`.
  - `req_tx_data_get[g]` = `tx_data_get`, combinational; all other `req_tx_data_get` bits are 0.
  - When `tx_pkt_end` is sampled: clear `pending[g]`, load the gap counter with IPG_CYCLES-1, go to GAP.
- **GAP**
  - `req_pkt_end[g]`=1 during the first GAP cycle only.
  - `grant`=0 throughout.
  - The counter decrements each cycle; at 0 go to IDLE.
- **Outside BUSY**
  - `tx_data_avail`=0, `tx_data`=0, all `req_tx_data_get`=0.
  - `tx_data_get` and `tx_pkt_end` are ignored.
- **Requests during arbitration.** A request from the grantee arriving while it is in START or BUSY is ignored, because `pending[g]` is still 1.
- **Simultaneous request and completion.** `req_pkt_start[g]` in the same cycle as the `tx_pkt_end` clear leaves `pending[g]`=1 and captures the new PID; the set wins over the clear.
- **Other requesters.** Requests from non-grantees are latched in every state.
- **Reset.**
  - All state clears: `pending`=0, PID registers=0, state=IDLE, `last`=NUM_REQ-1 so requester 0 wins first, counter=0.
  - All outputs are 0.
  - Reset mid-packet drops the packet silently, with no `req_pkt_end`.

## Timing
- **Request to start.** With the arbiter idle and `req_pkt_start[i]` in cycle N:
  - `pending[i]` and `req_busy[i]` are high in N+1.
  - `grant` and the START state apply in N+2, with `tx_pkt_start` high in N+2 only.
  - BUSY begins in N+3.
- **Completion.** With `tx_pkt_end` in cycle M:
  - `req_pkt_end[g]` is high and `req_busy[g]` drops in M+1.
  - GAP covers M+1..M+IPG_CYCLES.
  - IDLE is reached in M+IPG_CYCLES+1, and the next `tx_pkt_start` is no earlier than M+IPG_CYCLES+2.
- **Data path.** Mux and get-steering are combinational in BUSY; zero added latency.
- **Outputs.** All outputs except the data mux and `req_tx_data_get` are registered.

## Test plan
- **Single requester:** `req_pkt_start[1]` pulse with PID 4'b0011 at cycle 10 -> `req_busy[1]` high at 11; `grant`=4'b0010 and `tx_pkt_start` with `tx_pid`=3 at 12 only.
- **Data steering:** requester 1 supplies bytes 0xA5 and 0x5A and the transmitter pulses `tx_data_get` twice -> `req_tx_data_get[1]` pulses twice and other bits stay 0; `tx_pkt_end` at cycle M -> `req_pkt_end[1]` at M+1 and next IDLE at M+17.
- **Round-robin:** all four request in the same cycle after reset -> grant order 0,1,2,3; then requester 0 re-requests during requester 3's packet and requester 2 re-requests during requester 0's packet -> grant order 0, then 2.
- **Duplicate and collision:**
  - A second `req_pkt_start[0]` with PID 4'b1010 while packet 0 (PID 4'b0010) is pending -> the transmitted PID is still 4'b0010.
  - A request in the same cycle as `tx_pkt_end` -> `req_busy` stays 1 and a new packet follows after the gap.
- **Isolation:** a non-grantee toggles `req_tx_data_avail` during BUSY, and `tx_data_get`/`tx_pkt_end` pulses arrive in IDLE or GAP -> no effect on `tx_data_avail`, `pending` or any `req_*` outputs.
- **Reset mid-packet:** assert `reset` low in BUSY -> all outputs 0 immediately and no `req_pkt_end`; after release, a new request is granted with requester 0 first.
